// File: rtl/slab_hit_collector_if.sv
// Handshake bundle between the slab comparators, the hit collector and its consumer.
// The collector uses the slave modport; the issuing/consuming side uses master.
interface slab_hit_collector_if #(
  parameter int IDW  = 16,
  parameter int NCMP = 3
);
  logic            in_valid;
  logic [IDW-1:0]  in_id;
  logic            in_ready;
  logic [NCMP-1:0] le_flags;
  logic            out_valid;
  logic            out_ready;
  logic [IDW-1:0]  out_id;
  logic            out_hit;

  modport master (
    output in_valid, in_id, le_flags, out_ready,
    input  in_ready, out_valid, out_id, out_hit
  );

  modport slave (
    input  in_valid, in_id, le_flags, out_ready,
    output in_ready, out_valid, out_id, out_hit
  );
endinterface

// File: rtl/slab_hit_collector.sv
// Tags comparator results with their ray id, ANDs the slab flags into one hit bit,
// buffers results in a show-ahead FIFO and grants upstream credits so nothing is dropped.
module slab_hit_collector #(
  parameter int LAT   = 3,
  parameter int NCMP  = 3,
  parameter int IDW   = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  slab_hit_collector_if.slave  bus,
  output logic [CW-1:0]        ray_count,
  output logic [CW-1:0]        hit_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int IFW  = $clog2(LAT + 1);
  localparam int OW   = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT:1]   dl_vld_r;
  logic [IDW-1:0] dl_id_r [1:LAT];
  logic [IFW-1:0] inflight_r;

  logic [IDW-1:0]  mem_id_r [DEPTH];
  logic [DEPTH-1:0] mem_hit_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic [CW-1:0]   ray_count_r;
  logic [CW-1:0]   hit_count_r;

  logic [OW-1:0] occ_s;
  logic          ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          hit_s;

  // Credit check counts both rays still in the delay line and rays already buffered,
  // so a push can never find the FIFO full.
  always_comb begin
    occ_s    = OW'(inflight_r) + OW'(count_r);
    ready_s  = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else begin
      ready_s = (occ_s < OW'(DEPTH));
    end
    accept_s = bus.in_valid && ready_s;
    push_s   = dl_vld_r[LAT];
    hit_s    = &bus.le_flags;
    pop_s    = (count_r != {CNTW{1'b0}}) && bus.out_ready;
  end

  // Tag delay line aligning ray ids with the comparator outputs, plus in-flight counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld_r   <= '0;
      inflight_r <= '0;
      for (int i = 1; i <= LAT; i++) begin
        dl_id_r[i] <= '0;
      end
    end else begin
      dl_vld_r[1] <= accept_s;
      dl_id_r[1]  <= bus.in_id;
      for (int i = 2; i <= LAT; i++) begin
        dl_vld_r[i] <= dl_vld_r[i-1];
        dl_id_r[i]  <= dl_id_r[i-1];
      end
      case ({accept_s, push_s})
        2'b10:   inflight_r <= inflight_r + IFW'(1);
        2'b01:   inflight_r <= inflight_r - IFW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Result FIFO storage, pointers, occupancy and ray/hit statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      mem_hit_r   <= '0;
      ray_count_r <= '0;
      hit_count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_id_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_id_r[wr_ptr_r]  <= dl_id_r[LAT];
        mem_hit_r[wr_ptr_r] <= hit_s;
        wr_ptr_r            <= wr_ptr_r + AW'(1);
        ray_count_r         <= ray_count_r + CW'(1);
        if (hit_s) begin
          hit_count_r <= hit_count_r + CW'(1);
        end else begin
          hit_count_r <= hit_count_r;
        end
      end else begin
        wr_ptr_r    <= wr_ptr_r;
        ray_count_r <= ray_count_r;
        hit_count_r <= hit_count_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = (count_r != {CNTW{1'b0}});
  assign bus.out_id    = mem_id_r[rd_ptr_r];
  assign bus.out_hit   = mem_hit_r[rd_ptr_r];
  assign ray_count     = ray_count_r;
  assign hit_count     = hit_count_r;
endmodule

// File: tb/tb_slab_hit_collector.sv
// Self-checking bench: directed scenarios then randomized traffic, all compared against
// a queue-based reference model of issue -> (LAT cycles) -> combine -> FIFO -> consumer.
module tb_slab_hit_collector;
  localparam int LAT   = 3;
  localparam int NCMP  = 3;
  localparam int IDW   = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 32;

  logic          clk;
  logic          rst;
  logic [CW-1:0] ray_count;
  logic [CW-1:0] hit_count;

  slab_hit_collector_if #(.IDW(IDW), .NCMP(NCMP)) bus ();

  slab_hit_collector #(.LAT(LAT), .NCMP(NCMP), .IDW(IDW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ray_count (ray_count),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [IDW-1:0] id; int due; } pend_t;
  typedef struct { logic [IDW-1:0] id; logic hit; } res_t;

  pend_t         pq[$];
  res_t          eq[$];
  logic [CW-1:0] m_rays;
  logic [CW-1:0] m_hits;
  int            cyc;
  int            n_cmp;
  int            n_bad;
  bit            chk;
  int            n_acc;
  int            n_pop;
  int            n_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: compare DUT against the model at the negedge, then advance the model.
  task automatic step();
    pend_t p;
    res_t  r;
    bit    m_ready, acc, pop, push;
    @(negedge clk);
    m_ready = !rst && ((pq.size() + eq.size()) < DEPTH);
    if (chk) begin
      check("in_ready", 64'(bus.in_ready), 64'(m_ready));
      check("out_valid", 64'(bus.out_valid), 64'(eq.size() != 0));
      if (eq.size() != 0) begin
        check("out_id", 64'(bus.out_id), 64'(eq[0].id));
        check("out_hit", 64'(bus.out_hit), 64'(eq[0].hit));
      end
      check("ray_count", 64'(ray_count), 64'(m_rays));
      check("hit_count", 64'(hit_count), 64'(m_hits));
    end
    if (!bus.in_ready) n_stall++;
    acc  = bus.in_valid && m_ready;
    pop  = bus.out_ready && (eq.size() != 0);
    push = (pq.size() != 0) && (pq[0].due == cyc);
    if (acc) n_acc++;
    if (pop) n_pop++;
    if (rst) begin
      pq.delete();
      eq.delete();
      m_rays = '0;
      m_hits = '0;
    end else begin
      if (pop) void'(eq.pop_front());
      if (push) begin
        p     = pq.pop_front();
        r.id  = p.id;
        r.hit = &bus.le_flags;
        eq.push_back(r);
        m_rays = m_rays + 1;
        if (r.hit) m_hits = m_hits + 1;
      end
      if (acc) begin
        p.id  = bus.in_id;
        p.due = cyc + LAT;
        pq.push_back(p);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_id     = '0;
    bus.le_flags  = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; chk = 1'b0;
    m_rays = '0; m_hits = '0;
    rst = 1'b1;
    idle_inputs();
    step();
    chk = 1'b1;
    step();
    rst = 1'b0;

    // Single ray with a hit
    for (int i = 0; i < 3; i++) step();
    bus.in_valid = 1'b1; bus.in_id = 16'h0005;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    bus.le_flags = 3'b111;
    step();
    bus.le_flags = 3'b000;
    step();
    check("single_out_valid", 64'(bus.out_valid), 64'd1);
    check("single_out_id", 64'(bus.out_id), 64'h0005);
    check("single_ray_count", 64'(ray_count), 64'd1);
    check("single_hit_count", 64'(hit_count), 64'd1);

    // Miss combine: three rays, only the last hits
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c < 3);
      bus.in_id    = IDW'(c + 1);
      bus.le_flags = (c == 3) ? 3'b110 : (c == 4) ? 3'b011 : (c == 5) ? 3'b111 : 3'b000;
      step();
    end
    check("miss_ray_count", 64'(ray_count), 64'd3);
    check("miss_hit_count", 64'(hit_count), 64'd1);
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

    // Backpressure: credits stop exactly at DEPTH
    do_reset();
    idle_inputs();
    n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = 1'b1;
      bus.in_id    = IDW'(16'h0100 + c);
      bus.le_flags = NCMP'($urandom);
      step();
    end
    check("bp_accepts", 64'(n_acc), 64'd8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    bus.out_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 10; c++) step();
    check("bp_drained", 64'(n_pop), 64'd7);

    // Full throughput with simultaneous push/pop
    do_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    n_stall = 0; n_pop = 0;
    for (int c = 0; c < 26; c++) begin
      bus.in_valid = (c < 20);
      bus.in_id    = IDW'(16'h0200 + c);
      bus.le_flags = NCMP'($urandom);
      step();
    end
    check("ft_stalls", 64'(n_stall), 64'd0);
    check("ft_outputs", 64'(n_pop), 64'd20);

    // Flags toggling with no issues
    do_reset();
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      bus.le_flags = NCMP'($urandom);
      step();
    end
    check("idle_rays", 64'(ray_count), 64'd0);
    check("idle_hits", 64'(hit_count), 64'd0);

    // Reset mid-stream: buffered and in-flight rays are discarded
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_id    = IDW'(16'h0300 + c);
      bus.le_flags = 3'b111;
      step();
    end
    bus.in_valid = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.le_flags = 3'b111;
      step();
    end
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ray_count", 64'(ray_count), 64'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_id     = IDW'($urandom);
      bus.le_flags  = ($urandom_range(0, 2) == 0) ? 3'b111 : NCMP'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) step();
    check("final_empty", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/slab_hit_collector.md
Name: slab_hit_collector

Overview:
- Sits directly downstream of the per-slab less_or_equal comparators in the Ray_AABB_11_20 datapath.
- Tracks which ray each comparator result belongs to and combines the NCMP flags into a single hit bit per ray.
- Buffers results in a small FIFO and presents them on a valid/ready output.
- Issues credits upstream so no comparator result is ever dropped, and keeps ray/hit statistics.

Parameters:
- LAT, 3, cycles from operands presented to the comparators to their less_or_equal outputs being valid (FPSub pipeline plus output register); must be >= 1.
- NCMP, 3, number of comparator flags combined per ray.
- IDW, 16, ray identifier width.
- DEPTH, 8, result FIFO depth; power of two, >= 2.
- CW, 32, statistics counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream issues comparator operands for ray in_id this cycle.
- in_id  in  IDW  ray identifier accompanying the issue.
- in_ready  out  1  credit available; the upstream stage issues only when in_valid && in_ready.
- le_flags  in  NCMP  comparator less_or_equal outputs; bit i = comparator i.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts the head.
- out_id  out  IDW  ray id of the head entry.
- out_hit  out  1  AND of all NCMP flags for that ray.
- ray_count  out  CW  rays written into the FIFO since reset.
- hit_count  out  CW  rays written with hit=1 since reset.

Behaviour:
- Reset: one clock, synchronous, active-high; rst sampled high on a clk edge clears all state.
  - Outputs cleared: out_valid=0, out_id=0, out_hit=0, ray_count=0, hit_count=0.
  - Delay line, FIFO pointers and credit count are cleared.
  - in_ready=0 while rst is high and 1 in the first cycle after.
  - Reset mid-operation discards all in-flight and buffered rays; comparator results arriving afterwards are ignored because their delay-line valid was cleared.
- Accept: an issue is accepted in cycle T when in_valid && in_ready.
  - in_valid while in_ready=0 is ignored; the upstream stage must not issue operands then.
- Tag delay line: LAT registered stages carrying {valid, id}. An issue accepted in cycle T appears at stage LAT in cycle T+LAT, aligned with le_flags for that ray.
- Combine: in cycle T+LAT, if the stage-LAT valid is set, write {id, &le_flags} into the FIFO at the end of that cycle.
  - le_flags are ignored in any cycle whose stage-LAT valid is 0.
- FIFO: show-ahead, registered, no fall-through.
  - out_valid = (count != 0); the entry written at the end of T+LAT is first visible in cycle T+LAT+1.
  - Pop when out_valid && out_ready. out_id and out_hit are stable while out_valid && !out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Credit: occupancy = inflight + count.
  - inflight = number of valid delay-line stages, maintained as a counter.
  - in_ready = (occupancy < DEPTH), computed from registered state.
  - This guarantees a push never occurs when the FIFO is full.
  - A pop in cycle T frees a credit visible from cycle T+1.
- Latency: minimum issue-to-out_valid is LAT+1 cycles. Sustained throughput is 1 ray/cycle when out_ready is held at 1.
- Statistics:
  - ray_count increments on every FIFO push.
  - hit_count increments on every push with hit=1.
  - Both wrap modulo 2^CW with no saturation.
- Ordering: output order equals issue order.

Test Plan:
- Single ray: after reset, issue id=0x0005 in cycle 10; le_flags=3'b111 in cycle 13 -> out_valid=1 in cycle 14 with out_id=0x0005, out_hit=1; ray_count=1, hit_count=1.
- Miss combine: issue ids 1,2,3 back-to-back with flags 3'b110, 3'b011, 3'b111 at +LAT -> outputs (1,0), (2,0), (3,1) in order; hit_count=1, ray_count=3.
- Backpressure/credit: out_ready=0, in_valid held high -> exactly 8 issues accepted; in_ready=0 from the cycle after the 8th acceptance; out_valid stays with head id stable. Then out_ready=1 for one cycle -> in_ready=1 the next cycle; all 8 drain in order.
- Simultaneous push/pop at full throughput: 20 consecutive issues with out_ready=1 -> in_ready never drops; 20 outputs, one per cycle, starting 4 cycles after the first issue.
- Ignored flags: le_flags toggling with no issues -> no pushes; counters stay 0.
- Reset mid-stream: 3 rays in flight and 2 buffered, assert rst one cycle -> out_valid=0, counters=0, in_ready=1 next cycle; stale flags arriving afterwards produce no output.
